// File: rtl/graphics_pkg.sv
// graphics_pkg: shared constants for the Curveball display path.
//
// Contents:
//   COORD_W           - width of pixel_x / pixel_y coordinate buses
//   DEF_H_* / DEF_V_* - default 640x480@60 raster timing (pixels / lines)
//   Color constants   - 24-bit RGB 8:8:8 values used by the sprite renderers
//   axis_total()      - length of one scan axis from its four timing regions
package graphics_pkg;

    localparam int unsigned COORD_W = 16;

    // Horizontal timing, in pixel ticks.
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;

    // Vertical timing, in lines.
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned DEF_H_TOTAL =
        DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL =
        DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // RGB 8:8:8 palette shared by the renderers.
    localparam logic [23:0] BLACK  = 24'h000000;
    localparam logic [23:0] BLUE   = 24'h0000FF;
    localparam logic [23:0] GREEN  = 24'h00FF00;
    localparam logic [23:0] RED    = 24'hFF0000;
    localparam logic [23:0] YELLOW = 24'hFFFF00;
    localparam logic [23:0] GRAY   = 24'h808080;
    localparam logic [23:0] WHITE  = 24'hFFFFFF;

    function automatic int unsigned axis_total(input int unsigned vis,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return vis + fp + sync + bp;
    endfunction

endpackage

// File: rtl/scan_axis_counter.sv
// scan_axis_counter: one axis of the raster scan.
//
// Wrapping counter 0..TOTAL-1 that advances on clocks with en=1, plus a
// combinational decode of the window [WIN_START, WIN_START+WIN_LEN).
//
// Ports:
//   clk    in  1      system clock
//   rst_n  in  1      asynchronous active-low reset (count returns to 0)
//   en     in  1      advance enable
//   cnt    out WIDTH  current count (register output)
//   wrap   out 1      count is at TOTAL-1; next enabled clock returns to 0
//   in_win out 1      count lies inside the decode window
module scan_axis_counter
    import graphics_pkg::*;
#(
    parameter int unsigned WIDTH     = COORD_W,
    parameter int unsigned TOTAL     = DEF_H_TOTAL,
    parameter int unsigned WIN_START = DEF_H_ACTIVE + DEF_H_FP,
    parameter int unsigned WIN_LEN   = DEF_H_SYNC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap,
    output logic             in_win
);

    localparam logic [WIDTH-1:0] LAST   = WIDTH'(TOTAL - 1);
    localparam logic [WIDTH-1:0] WIN_LO = WIDTH'(WIN_START);
    localparam logic [WIDTH-1:0] WIN_HI = WIDTH'(WIN_START + WIN_LEN);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign wrap = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Half-open window, decoded straight off the register so the
    // sync stage sees the state that belongs to the current coordinate.
    assign in_win = (cnt_q >= WIN_LO) && (cnt_q < WIN_HI);
    assign cnt    = cnt_q;

endmodule

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: raster timing generator and pixel-output stage.
//
// Scans the frame one pixel per pix_en tick, publishes the scan position to
// the combinational sprite renderers, and registers their merged color onto
// the DAC bus together with the sync state of the same coordinate.
//
// Ports:
//   clk         in  1   system clock
//   rst_n       in  1   asynchronous active-low reset
//   pix_en      in  1   pixel-rate clock enable
//   color       in  24  renderer RGB for the current pixel_x/pixel_y
//   pixel_x     out 16  horizontal scan count (unclamped in blanking)
//   pixel_y     out 16  vertical scan count (unclamped in blanking)
//   active      out 1   current coordinate is in the visible area
//   rgb         out 24  registered pixel, black outside the visible area
//   hsync       out 1   horizontal sync, aligned with rgb
//   vsync       out 1   vertical sync, aligned with rgb
//   line_start  out 1   one-clk pulse when h count becomes 0
//   frame_start out 1   one-clk pulse when the scan becomes (0,0)
module vga_scan_gen
    import graphics_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_en,
    input  logic [23:0]        color,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               active,
    output logic [23:0]        rgb,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [COORD_W-1:0] H_VIS = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_VIS = COORD_W'(V_ACTIVE);

    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic               h_wrap;
    logic               v_wrap;
    logic               h_sync_win;
    logic               v_sync_win;
    logic               v_en;

    logic [23:0] rgb_q;
    logic        hsync_q;
    logic        vsync_q;
    logic        line_start_q;
    logic        frame_start_q;

    // The vertical axis steps once per line, on the tick that wraps h.
    assign v_en = pix_en & h_wrap;

    scan_axis_counter #(
        .WIDTH     (COORD_W),
        .TOTAL     (H_TOTAL),
        .WIN_START (H_ACTIVE + H_FP),
        .WIN_LEN   (H_SYNC)
    ) u_h_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (pix_en),
        .cnt    (h_cnt),
        .wrap   (h_wrap),
        .in_win (h_sync_win)
    );

    // vsync window depends on v only, so it spans whole lines.
    scan_axis_counter #(
        .WIDTH     (COORD_W),
        .TOTAL     (V_TOTAL),
        .WIN_START (V_ACTIVE + V_FP),
        .WIN_LEN   (V_SYNC)
    ) u_v_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (v_en),
        .cnt    (v_cnt),
        .wrap   (v_wrap),
        .in_win (v_sync_win)
    );

    assign active = (h_cnt < H_VIS) && (v_cnt < V_VIS);

    // Output stage: color returned for the current coordinate is captured
    // alongside that coordinate's sync state, giving one tick of latency.
    // The counter -> renderer -> rgb path is single-cycle in clk; pix_en
    // only gates when the capture happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q   <= BLACK;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
        end else if (pix_en) begin
            rgb_q   <= active ? color : BLACK;
            // XOR with ~SYNC_POL maps "in window" to the asserted level.
            hsync_q <= h_sync_win ^ ~SYNC_POL;
            vsync_q <= v_sync_win ^ ~SYNC_POL;
        end
    end

    // Strobes are high on the clk where the counters have just become 0.
    // A reset restart never passes through a wrap, so it emits no strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= pix_en & h_wrap;
            frame_start_q <= pix_en & h_wrap & v_wrap;
        end
    end

    assign pixel_x     = h_cnt;
    assign pixel_y     = v_cnt;
    assign rgb         = rgb_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
